// File: rtl/card_init_ctl.sv
// card_init_ctl
// Builds a fresh board in the card register file at the start of each game.
// On an accepted new_game request it zeroes every card slot 1..2**ADDR_W-1,
// resets the colour generator for one cycle, then steps the generator and
// copies each card word it produces into the register file. When the
// generator reports its last card, the board is flagged ready.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   new_game            start request (IDLE / READY / ERROR only)
//   num_of_cards        slot count incl. reserved slot 0; must be odd and >= 3
//   gen_done            generator is presenting its last card
//   gen_address         generator current card address
//   gen_data            generator card word for gen_address
//   gen_rst             generator synchronous reset (also follows rst)
//   gen_enable          generator advance
//   wr_en/wr_addr/wr_data  registered register-file write port
//   busy                init in progress
//   ready               board valid
//   init_done           one-cycle pulse on the first READY cycle
//   err                 rejected request or generator timeout
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for the first request after reset
// CLEAR   | zeroing slots 1..2**ADDR_W-1, one per cycle
// GEN_RST | one-cycle generator reset
// FILL    | copying generator cards into the register file
// READY   | board valid, waiting for the next game
// ERROR   | bad request or generator timeout, waiting for a new request

module card_init_ctl #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 14,
    parameter int NUM_W   = 5,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              new_game,
    input  logic [NUM_W-1:0]  num_of_cards,
    input  logic              gen_done,
    input  logic [ADDR_W-1:0] gen_address,
    input  logic [DATA_W-1:0] gen_data,
    output logic              gen_rst,
    output logic              gen_enable,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              ready,
    output logic              init_done,
    output logic              err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_GEN_RST = 3'd2;
    localparam logic [2:0] S_FILL    = 3'd3;
    localparam logic [2:0] S_READY   = 3'd4;
    localparam logic [2:0] S_ERROR   = 3'd5;

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [ADDR_W-1:0] clr_addr;
    logic [TW-1:0]     fill_cnt;
    logic              accept;
    logic              req_ok;
    logic              fill_wr;

    assign accept  = new_game && (state == S_IDLE || state == S_READY || state == S_ERROR);
    // The card count is only qualified here; the generator consumes it itself
    // and signals the last card through gen_done.
    assign req_ok  = num_of_cards[0] && (num_of_cards >= NUM_W'(3));
    // Slot 0 is reserved, so the generator's first (address 0) cycle writes nothing.
    assign fill_wr = (state == S_FILL) && (gen_address != '0);

    assign gen_rst    = rst || (state == S_GEN_RST);
    assign gen_enable = (state == S_FILL) && !gen_done;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_READY, S_ERROR: begin
                if (accept) state_nxt = req_ok ? S_CLEAR : S_ERROR;
            end
            S_CLEAR: begin
                if (clr_addr == '1) state_nxt = S_GEN_RST;
            end
            S_GEN_RST: state_nxt = S_FILL;
            S_FILL: begin
                if (gen_done)            state_nxt = S_READY;
                else if (fill_cnt == '0) state_nxt = S_ERROR;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            clr_addr  <= '0;
            fill_cnt  <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            init_done <= 1'b0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;

            if (accept)
                clr_addr <= ADDR_W'(1);
            else if (state == S_CLEAR)
                clr_addr <= clr_addr + ADDR_W'(1);

            // Down-counter over the FILL window; terminal count 0 with no
            // gen_done means the generator never finished.
            if (state == S_GEN_RST)
                fill_cnt <= TW'(TIMEOUT - 1);
            else if (state == S_FILL && fill_cnt != '0)
                fill_cnt <= fill_cnt - TW'(1);

            if (state == S_CLEAR) begin
                wr_en   <= 1'b1;
                wr_addr <= clr_addr;
                wr_data <= '0;
            end else if (fill_wr) begin
                wr_en   <= 1'b1;
                wr_addr <= gen_address;
                wr_data <= gen_data;
            end else begin
                wr_en   <= 1'b0;
                wr_addr <= '0;
                wr_data <= '0;
            end

            busy      <= (state_nxt == S_CLEAR) || (state_nxt == S_GEN_RST) || (state_nxt == S_FILL);
            ready     <= (state_nxt == S_READY);
            init_done <= (state_nxt == S_READY) && (state != S_READY);
            err       <= (state_nxt == S_ERROR);
        end
    end

endmodule

// File: tb/tb_card_init_ctl.sv
module tb_card_init_ctl;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 14;
    localparam int NUM_W  = 5;

    localparam int K_OK  = 0;
    localparam int K_BAD = 1;
    localparam int K_TMO = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              new_game;
    logic [NUM_W-1:0]  num_of_cards;
    logic              gen_done;
    logic [ADDR_W-1:0] gen_address;
    logic [DATA_W-1:0] gen_data;
    logic              gen_rst;
    logic              gen_enable;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              ready;
    logic              init_done;
    logic              err;

    int tests = 0;
    int fails = 0;

    // generator model
    int   model_n  = 13;
    logic gen_tie0 = 1'b0;
    logic [DATA_W-1:0] mem [0:31];

    card_init_ctl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_W(NUM_W), .TIMEOUT(32)) dut (
        .clk(clk), .rst(rst), .new_game(new_game), .num_of_cards(num_of_cards),
        .gen_done(gen_done), .gen_address(gen_address), .gen_data(gen_data),
        .gen_rst(gen_rst), .gen_enable(gen_enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .ready(ready), .init_done(init_done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] gen_word(input int a);
        logic [11:0] rgb;
        rgb = 12'(a * 149 + 7);
        return {rgb, 1'b0, 1'b1};
    endfunction

    always_ff @(posedge clk) begin
        if (gen_rst)         gen_address <= '0;
        else if (gen_enable) gen_address <= gen_address + 5'd1;
    end
    assign gen_done = !gen_tie0 && (int'(gen_address) == model_n - 1);
    assign gen_data = gen_word(int'(gen_address));

    typedef struct {
        string name;
        int    n;
        bit    tie0;
        bit    pulse;
        int    kind;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_game(input int n, input bit tie0);
        @(negedge clk);
        num_of_cards = NUM_W'(n);
        gen_tie0     = tie0;
        model_n      = n;
        new_game     = 1'b1;
        @(posedge clk);
        #1 new_game = 1'b0;
    endtask

    task automatic run_game(input vec_t v);
        int wk[$];
        int wa[$];
        int wd[$];
        int grst_cnt = 0, grst_k = -1, id_cnt = 0, id_k = -1;
        int rdy_k = -1, err_k = -1, done_k = -1, busy1 = 0, busy_done = -1;
        int bad, nfill;
        start_game(v.n, v.tie0);
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (wr_en) begin
                wk.push_back(k); wa.push_back(int'(wr_addr)); wd.push_back(int'(wr_data));
                mem[wr_addr] = wr_data;
            end
            if (gen_rst) begin grst_cnt++; grst_k = k; end
            if (init_done) begin id_cnt++; id_k = k; end
            if (ready && rdy_k < 0) rdy_k = k;
            if (err && err_k < 0) err_k = k;
            if (k == 1) busy1 = int'(busy);
            if (done_k < 0 && (ready || err)) begin done_k = k; busy_done = int'(busy); end
            new_game = v.pulse && (k == 10 || k == 40);
            if (done_k >= 0 && k >= done_k + 3) break;
        end
        new_game = 1'b0;
        chk({v.name, " finished"}, int'(done_k >= 0), 1);
        if (v.kind == K_BAD) begin
            chk({v.name, " wr_count"}, wk.size(), 0);
            chk({v.name, " gen_rst"}, grst_cnt, 0);
            chk({v.name, " err_k"}, err_k, 1);
            chk({v.name, " ready_k"}, rdy_k, -1);
        end else begin
            nfill = (v.kind == K_TMO) ? 31 : v.n - 1;
            chk({v.name, " wr_count"}, wk.size(), 31 + nfill);
            bad = 0;
            for (int i = 0; i < 31 && i < wk.size(); i++)
                if (wk[i] != i + 2 || wa[i] != i + 1 || wd[i] != 0) bad++;
            chk({v.name, " clear_seq_errs"}, bad, 0);
            bad = 0;
            for (int j = 0; j < nfill && 31 + j < wk.size(); j++)
                if (wk[31+j] != 35 + j || wa[31+j] != j + 1 || wd[31+j] != int'(gen_word(j + 1))) bad++;
            chk({v.name, " fill_seq_errs"}, bad, 0);
            chk({v.name, " gen_rst_cnt"}, grst_cnt, 1);
            chk({v.name, " gen_rst_k"}, grst_k, 32);
            chk({v.name, " busy_first"}, busy1, 1);
            chk({v.name, " busy_at_done"}, busy_done, 0);
            if (v.kind == K_OK) begin
                chk({v.name, " ready_k"}, rdy_k, 33 + v.n);
                chk({v.name, " init_done_cnt"}, id_cnt, 1);
                chk({v.name, " init_done_k"}, id_k, 33 + v.n);
                chk({v.name, " err_k"}, err_k, -1);
                bad = 0;
                for (int a = 0; a < 32; a++)
                    if (mem[a] != ((a != 0 && a < v.n) ? gen_word(a) : '0)) bad++;
                chk({v.name, " board_errs"}, bad, 0);
            end else begin
                chk({v.name, " err_k"}, err_k, 65);
                chk({v.name, " ready_k"}, rdy_k, -1);
                chk({v.name, " init_done_cnt"}, id_cnt, 0);
                chk({v.name, " gen_enable_after"}, int'(gen_enable), 0);
            end
        end
    endtask

    task automatic abort_at(input string name, input int abort_k, input int exp_addr);
        start_game(13, 1'b0);
        for (int k = 1; k < abort_k; k++) @(negedge clk);
        @(negedge clk);
        chk({name, " pre_rst_wr_en"}, int'(wr_en), 1);
        chk({name, " pre_rst_addr"}, abort_k >= 33 ? int'(gen_address) : int'(wr_addr) + 1, exp_addr);
        rst = 1'b1;
        #1;
        chk({name, " outs_in_rst"}, int'({wr_en, busy, ready, err, init_done, gen_enable, gen_rst}), 7'b0000001);
        @(negedge clk);
        chk({name, " outs_held_rst"}, int'({wr_en, busy, ready, err, init_done, gen_enable, gen_rst}), 7'b0000001);
        rst = 1'b0;
        @(negedge clk);
        chk({name, " outs_after_rst"}, int'({wr_en, busy, ready, err, init_done, gen_rst}), 0);
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{"n13",      13, 1'b0, 1'b0, K_OK};
        vecs[1] = '{"n12",      12, 1'b0, 1'b0, K_BAD};
        vecs[2] = '{"n1",        1, 1'b0, 1'b0, K_BAD};
        vecs[3] = '{"recover",  13, 1'b0, 1'b0, K_OK};
        vecs[4] = '{"timeout",  13, 1'b1, 1'b0, K_TMO};
        vecs[5] = '{"pulses",   13, 1'b0, 1'b1, K_OK};
        vecs[6] = '{"b2b13",    13, 1'b0, 1'b0, K_OK};
        vecs[7] = '{"b2b5",      5, 1'b0, 1'b0, K_OK};
        vecs[8] = '{"n3",        3, 1'b0, 1'b0, K_OK};
        vecs[9] = '{"n31",      31, 1'b0, 1'b0, K_OK};

        for (int a = 0; a < 32; a++) mem[a] = '0;
        rst = 1'b1; new_game = 1'b0; num_of_cards = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", int'({wr_en, busy, ready, err, init_done, gen_enable, gen_rst}), 7'b0000001);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outs", int'({wr_en, busy, ready, err, init_done, gen_rst}), 0);

        for (int i = 0; i < 10; i++) run_game(vecs[i]);

        abort_at("rst_clear10", 10, 10);
        run_game(vecs[0]);
        abort_at("rst_fill5", 38, 5);
        run_game(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
